// File: rtl/fpu_pkg.sv
// fpu_pkg: shared encodings for the FPU issue block.
// Revision 1.0
`default_nettype none

package fpu_pkg;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;
  localparam int   SIGN_BIT = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ORDER = 2'd1,
    WAIT  = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/fpu_res_fifo.sv
// fpu_res_fifo: tagged result FIFO, head entry presented combinationally.
// Revision 1.0
`default_nettype none

module fpu_res_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/fpu_issue.sv
// fpu_issue: issues one float add/sub at a time to an order/accepted/done unit
// and returns tagged results through a valid/ready write-back port. Revision 1.0
`default_nettype none

module fpu_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TAGW    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [TAGW-1:0] req_tag,
  output logic            order,
  input  logic            accepted,
  input  logic            done,
  output logic [31:0]     u_rs1,
  output logic [31:0]     u_rs2,
  input  logic [31:0]     u_rd,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [TAGW-1:0] wb_tag,
  output logic            err
);
  localparam int               CW        = $clog2(TIMEOUT + 1);
  localparam int               NW        = $clog2(DEPTH) + 1;
  localparam logic [NW-1:0]    FULL      = NW'(DEPTH);
  localparam logic [CW-1:0]    LAST      = CW'(TIMEOUT - 1);
  localparam logic [31:0]      SIGN_MASK = 32'h1 << SIGN_BIT;

  state_t            state, next_state;
  logic [31:0]       rs1_q, rs2_q;
  logic [TAGW-1:0]   tag_q;
  logic [CW-1:0]     cnt;
  logic              err_q;
  logic [NW-1:0]     count;
  logic [TAGW+31:0]  head;
  logic              push, start, set_err, timed_out;

  assign timed_out = (cnt == LAST);

  always_comb begin
    next_state = state;
    push       = 1'b0;
    start      = 1'b0;
    set_err    = 1'b0;
    req_ready  = 1'b0;
    order      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = (count < FULL);
        if (done) set_err = 1'b1;
        if (req_valid && req_ready) begin
          start      = 1'b1;
          next_state = ORDER;
        end
      end
      ORDER: begin
        order = 1'b1;
        // A completion in the final cycle takes priority over the timeout.
        if (accepted && done) begin
          push       = 1'b1;
          next_state = IDLE;
        end else if (timed_out) begin
          set_err    = 1'b1;
          next_state = IDLE;
        end else if (accepted) begin
          next_state = WAIT;
        end else if (done) begin
          set_err = 1'b1;
        end
      end
      WAIT: begin
        if (done) begin
          push       = 1'b1;
          next_state = IDLE;
        end else if (timed_out) begin
          set_err    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      tag_q <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= next_state;
      if (start) begin
        rs1_q <= req_rs1;
        rs2_q <= (req_op == OP_SUB) ? (req_rs2 ^ SIGN_MASK) : req_rs2;
        tag_q <= req_tag;
        cnt   <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
      if (set_err) err_q <= 1'b1;
    end
  end

  fpu_res_fifo #(
    .DEPTH (DEPTH),
    .W     (TAGW + 32)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data ({tag_q, u_rd}),
    .pop       (wb_ready),
    .head      (head),
    .count     (count)
  );

  assign u_rs1             = rs1_q;
  assign u_rs2             = rs2_q;
  assign err               = err_q;
  assign wb_valid          = (count != '0);
  assign {wb_tag, wb_data} = head;
endmodule

`default_nettype wire

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: scoreboard bench with an integer-valued fadd unit model.
// Revision 1.0
`default_nettype none

module tb_fpu_issue;
  localparam int DEPTH = 2, TAGW = 5, TIMEOUT = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic order, accepted = 1'b0, done = 1'b0;
  logic [31:0] u_rs1, u_rs2, u_rd = '0;
  logic wb_valid, wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [TAGW-1:0] wb_tag;
  logic err;

  always #5 clk = ~clk;

  fpu_issue #(.DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .order(order), .accepted(accepted), .done(done), .u_rs1(u_rs1),
    .u_rs2(u_rs2), .u_rd(u_rd), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_tag(wb_tag), .err(err)
  );

  int total = 0, bad = 0;
  typedef struct { logic [TAGW-1:0] tag; logic [31:0] data; } exp_t;
  exp_t sb[$];

  int cfg_acc_wait = 0;
  bit cfg_same = 0, cfg_never = 0, cfg_rand = 0;
  int spur_req = 0;
  int wb_mode = 1;  // 0 hold low, 1 hold high, 2 random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Exact IEEE single encoding of an integer with magnitude below 2^24.
  function automatic logic [31:0] enc(input int v);
    int m, p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if ((m >> i) != 0) p = i;
    return {(v < 0), 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  function automatic int dec(input logic [31:0] f);
    int e, mag;
    logic [23:0] sig;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    sig = {1'b1, f[22:0]};
    mag = int'(sig >> (150 - e));
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    int x, y;
    x = dec(a);
    y = dec(b);
    return enc(op ? (x - y) : (x + y));
  endfunction

  // Unit model: fadd of integer-valued floats, configurable busy/latency.
  initial begin
    int wait_left, spur_ack;
    bit seen, pend, same;
    logic [31:0] s1, s2, pend_val, r;
    wait_left = 0; spur_ack = 0; seen = 0; pend = 0;
    forever begin
      @(negedge clk);
      accepted = 1'b0;
      done     = 1'b0;
      u_rd     = $urandom;
      if (!rstn) begin
        seen = 0; pend = 0;
      end else if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        done = 1'b1;
      end else if (pend) begin
        done = 1'b1; u_rd = pend_val; pend = 0;
      end else if (order) begin
        if (!seen) begin
          seen = 1; s1 = u_rs1; s2 = u_rs2;
          wait_left = cfg_rand ? int'($urandom_range(0, 3)) : cfg_acc_wait;
        end else begin
          check("operand_hold", {u_rs1, u_rs2}, {s1, s2});
        end
        if (wait_left > 0) wait_left--;
        else begin
          accepted = 1'b1;
          seen = 0;
          r = enc(dec(u_rs1) + dec(u_rs2));
          same = cfg_rand ? bit'($urandom_range(0, 1)) : cfg_same;
          if (!cfg_never) begin
            if (same) begin done = 1'b1; u_rd = r; end
            else begin pend = 1; pend_val = r; end
          end
        end
      end
    end
  end

  always @(negedge clk) wb_ready = (wb_mode == 2) ? 1'($urandom_range(0, 1)) : (wb_mode == 1);

  // Monitor: compares every popped result against the scoreboard head.
  initial begin
    bit prev_hold;
    logic [TAGW+31:0] prev;
    exp_t e;
    prev_hold = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin prev_hold = 0; continue; end
      if (wb_valid && prev_hold) check("wb_hold", {wb_tag, wb_data}, prev);
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("wb_tag", wb_tag, e.tag);
          check("wb_data", wb_data, e.data);
        end
        prev_hold = 0;
      end else begin
        prev_hold = wb_valid;
        prev = {wb_tag, wb_data};
      end
    end
  end

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAGW-1:0] tag, input bit expect_res);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) begin check("req_ready_wait", 0, 1); return; end
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    @(posedge clk);
    if (expect_res) sb.push_back('{tag, model(op, a, b)});
    #1;
    req_valid = 1'b0; req_rs1 = $urandom; req_rs2 = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
    check("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    sb.delete();
    #1;
    check("rst_order", order, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb", {wb_tag, wb_data}, 0);
    check("rst_err", err, 0);
    check("rst_ops", {u_rs1, u_rs2}, 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic int rnd_int();
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_req_ready", req_ready, 1);

    // ADD with latency check.
    sb.push_back('{5'd3, 32'h40400000});
    issue(1'b0, 32'h3F800000, 32'h40000000, 5'd3, 0);
    check("add_order_c1", order, 1);
    check("add_wbv_c1", wb_valid, 0);
    @(posedge clk); #1;
    check("add_wbv_c2", wb_valid, 0);
    @(posedge clk); #1;
    check("add_wbv_c3", wb_valid, 1);
    check("add_rdy_c3", req_ready, 1);
    check("add_wb_c3", {wb_tag, wb_data}, {5'd3, 32'h40400000});
    drain();

    // SUB: sign of rs2 flipped towards the unit.
    sb.push_back('{5'd7, 32'h00000000});
    issue(1'b1, 32'h3F800000, 32'h3F800000, 5'd7, 0);
    check("sub_u_rs1", u_rs1, 32'h3F800000);
    check("sub_u_rs2", u_rs2, 32'hBF800000);
    drain();

    // Backpressure.
    wb_mode = 0;
    issue(1'b0, enc(rnd_int()), enc(rnd_int()), 5'd10, 1);
    issue(1'b1, enc(rnd_int()), enc(rnd_int()), 5'd11, 1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_full_rdy", req_ready, 0);
    check("bp_full_wbv", wb_valid, 1);
    repeat (2) begin @(posedge clk); #1; check("bp_hold_rdy", req_ready, 0); end
    wb_mode = 1;
    @(posedge clk); #1;
    wb_mode = 0;
    check("bp_pop_rdy", req_ready, 1);
    check("bp_pop_wbv", wb_valid, 1);
    issue(1'b0, enc(rnd_int()), enc(rnd_int()), 5'd12, 1);
    wb_mode = 1;
    drain();

    // Busy unit holds accepted low for 5 cycles.
    cfg_acc_wait = 5;
    issue(1'b1, enc(250), enc(-17), 5'd20, 1);
    repeat (5) begin check("busy_order", order, 1); @(posedge clk); #1; end
    drain();
    cfg_acc_wait = 0;

    // Unit never completes: timeout.
    cfg_never = 1;
    issue(1'b0, enc(1), enc(2), 5'd21, 0);
    repeat (7) @(posedge clk);
    #1;
    check("to_err_early", err, 0);
    @(posedge clk); #1;
    check("to_err", err, 1);
    check("to_order", order, 0);
    check("to_idle_rdy", req_ready, 1);
    repeat (3) begin @(posedge clk); #1; check("to_no_wb", wb_valid, 0); end
    do_reset();

    // Reset while in WAIT, then a spurious done in IDLE.
    issue(1'b0, enc(5), enc(6), 5'd22, 0);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("rw_order", order, 0);
    check("rw_wbv", wb_valid, 0);
    check("rw_err", err, 0);
    #2;
    rstn = 1'b1;
    cfg_never = 0;
    spur_req++;
    @(posedge clk); #1;
    check("spur_err", err, 1);
    check("spur_wbv", wb_valid, 0);
    repeat (2) begin @(posedge clk); #1; check("spur_no_wb", wb_valid, 0); end
    do_reset();

    // Randomised traffic.
    cfg_rand = 1;
    wb_mode = 2;
    for (int i = 0; i < 40; i++)
      issue(1'($urandom_range(0, 1)), enc(rnd_int()), enc(rnd_int()), TAGW'($urandom), 1);
    wb_mode = 1;
    drain();
    repeat (2) @(negedge clk);
    check("rand_err", err, 0);
    check("rand_wbv", wb_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
